spi_cmd_sequencer: RTL and testbench

Command front-end for the SPI master. Accepts queued transactions (16-bit SPI configuration word plus transmit data) over a valid/ready interface. Programs the master's configuration port and launches the transfer, then waits for end-of-transfer and returns the received word over a valid/ready response interface. Sits directly upstream of the SPI master and drives its `data_config`, `config_enable`, `data_send` and `send_data` inputs; consumes its `end_send` and `data_read` outputs.

---
 rtl/spi_seq_pkg.sv | 27 ++
 rtl/spi_cmd_sequencer_fifo.sv | 41 ++++
 rtl/spi_cmd_sequencer.sv | 137 +++++++++++++
 tb/tb_spi_cmd_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI command sequencer.
package spi_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_SETTLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } spi_seq_state_t;

  localparam int CFG_EN_BIT   = 0;
  localparam int CFG_HALT_BIT = 7;
  localparam int CMD_DATA_W   = 64;

  typedef struct packed {
    logic [15:0]           cfg;
    logic [CMD_DATA_W-1:0] data;
  } spi_cmd_t;

  // A command that disables or halts the master only reprograms it; nothing is sent.
  function automatic logic cfg_only(input logic [15:0] cfg);
    return !cfg[CFG_EN_BIT] || cfg[CFG_HALT_BIT];
  endfunction

endpackage

// File: rtl/spi_cmd_sequencer_fifo.sv
// Command FIFO: DEPTH entries, extra pointer MSB distinguishes full from empty.
module spi_cmd_fifo #(
  parameter int WIDTH = 80,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// SPI master command front-end: queues commands, configures and launches the master, returns the reply.
// Optional config cache (skip CONFIG/SETTLE on repeated config) enabled by macro SPI_SEQ_CFG_CACHE_EN.
module spi_cmd_sequencer
  import spi_seq_pkg::*;
#(
  parameter int          DATA_IN  = 64,
  parameter int          DATA_OUT = 32,
  parameter int          DEPTH    = 4,
  parameter logic [15:0] TIMEOUT  = 16'd4096
) (
  input  logic                CLK,
  input  logic                reset,
  // valid/ready on both cmd and rsp: a transfer happens on any edge where valid and ready
  // are both high; a raised valid holds with a stable payload until that edge.
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [15:0]         cmd_config,
  input  logic [DATA_IN-1:0]  cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_OUT-1:0] rsp_data,
  output logic                rsp_err,
  output logic [15:0]         data_config,
  output logic                config_enable,
  output logic [DATA_IN-1:0]  data_send,
  output logic                send_data,
  input  logic                end_send,
  input  logic [DATA_OUT-1:0] data_read,
  output logic                busy,
  output logic [2:0]          state_dbg
);

  spi_seq_state_t state, state_nxt;

  logic [15:0]         cfg_r;
  logic [DATA_IN-1:0]  data_r;
  logic [DATA_OUT-1:0] rsp_data_r;
  logic                rsp_err_r;
  logic [15:0]         cnt;
  logic                full, empty, pop, skip_cfg;
  logic [DATA_IN+15:0] fifo_dout;
  logic [15:0]         fifo_cfg;

  assign cmd_ready = !full && !reset;
  assign pop       = (state == S_IDLE) && !empty;
  assign fifo_cfg  = fifo_dout[DATA_IN+15:DATA_IN];

  spi_cmd_fifo #(.WIDTH(DATA_IN + 16), .DEPTH(DEPTH)) u_fifo (
    .CLK       (CLK),
    .reset     (reset),
    .push      (cmd_valid && cmd_ready),
    .push_data ({cmd_config, cmd_data}),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (full),
    .empty     (empty)
  );

`ifdef SPI_SEQ_CFG_CACHE_EN
  logic [15:0] cfg_cache;
  assign skip_cfg = !cfg_only(fifo_cfg) && (fifo_cfg == cfg_cache);
`else
  assign skip_cfg = 1'b0;
`endif

  assign data_config = cfg_r;
  assign data_send   = data_r;
  assign rsp_data    = rsp_data_r;
  assign rsp_err     = rsp_err_r;
  assign busy        = (state != S_IDLE);
  assign state_dbg   = state;

  always_comb begin
    state_nxt     = state;
    config_enable = 1'b0;
    send_data     = 1'b0;
    rsp_valid     = 1'b0;
    case (state)
      S_IDLE:   if (!empty) state_nxt = skip_cfg ? S_LAUNCH : S_CONFIG;
      S_CONFIG: begin
        config_enable = 1'b1;
        state_nxt     = S_SETTLE;
      end
      S_SETTLE: state_nxt = cfg_only(cfg_r) ? S_RESP : S_LAUNCH;
      S_LAUNCH: begin
        send_data = 1'b1;
        state_nxt = S_WAIT;
      end
      // end_send is checked first, so it wins over a coincident timeout
      S_WAIT:   if (end_send || (cnt == TIMEOUT - 16'd1)) state_nxt = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= S_IDLE;
      cfg_r      <= '0;
      data_r     <= '0;
      rsp_data_r <= '0;
      rsp_err_r  <= 1'b0;
      cnt        <= '0;
`ifdef SPI_SEQ_CFG_CACHE_EN
      cfg_cache  <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (pop) begin
        cfg_r  <= fifo_cfg;
        data_r <= fifo_dout[DATA_IN-1:0];
      end
`ifdef SPI_SEQ_CFG_CACHE_EN
      if (state == S_CONFIG) cfg_cache <= cfg_r;
`endif
      if (state == S_SETTLE && cfg_only(cfg_r)) begin
        rsp_data_r <= '0;
        rsp_err_r  <= 1'b0;
      end
      if (state == S_LAUNCH) cnt <= '0;
      if (state == S_WAIT) begin
        cnt <= cnt + 16'd1;
        if (end_send) begin
          rsp_data_r <= data_read;
          rsp_err_r  <= 1'b0;
        end else if (cnt == TIMEOUT - 16'd1) begin
          rsp_data_r <= '0;
          rsp_err_r  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Self-checking bench for spi_cmd_sequencer with a latency-programmable SPI master model.
module tb_spi_cmd_sequencer;

  localparam int DIN   = 64;
  localparam int DOUT  = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 48;
  localparam int W     = DOUT + 1;

  logic             CLK = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic [15:0]      cmd_config = '0;
  logic [DIN-1:0]   cmd_data = '0;
  logic             rsp_ready = 1'b0;
  logic             end_send = 1'b0;
  logic [DOUT-1:0]  data_read = '0;
  logic             cmd_ready, rsp_valid, rsp_err, config_enable, send_data, busy;
  logic [DOUT-1:0]  rsp_data;
  logic [15:0]      data_config;
  logic [DIN-1:0]   data_send;
  logic [2:0]       state_dbg;

  spi_cmd_sequencer #(
    .DATA_IN(DIN), .DATA_OUT(DOUT), .DEPTH(DEPTH), .TIMEOUT(16'(TMO))
  ) dut (
    .CLK(CLK), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_config(cmd_config), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .data_config(data_config), .config_enable(config_enable), .data_send(data_send),
    .send_data(send_data), .end_send(end_send), .data_read(data_read),
    .busy(busy), .state_dbg(state_dbg)
  );

  always #5 CLK = ~CLK;

  // Observations at the negedge after posedge k carry index k.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0]    exp_q[$];
  logic [15:0]     cfg_exp_q[$];
  logic [DIN-1:0]  sd_exp_q[$];
  int              lat_q[$];
  logic [DOUT-1:0] rd_q[$];
  logic [15:0]     last_cfg = '0;

  int ce_cnt = 0, sd_cnt = 0, last_ce = 0, last_sd = 0, first_rsp = 0, es_idx = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: decides the response of a command from its config and the master latency.
  task automatic model_accept(input logic [15:0] cfg, input logic [DIN-1:0] d,
                              input int lat, input logic [DOUT-1:0] rd);
    bit co, runs;
    co   = !cfg[0] || cfg[7];
    runs = 1'b1;
`ifdef SPI_SEQ_CFG_CACHE_EN
    runs = co || (cfg != last_cfg);
`endif
    if (runs) begin
      cfg_exp_q.push_back(cfg);
      last_cfg = cfg;
    end
    if (co) begin
      exp_q.push_back('0);
    end else begin
      sd_exp_q.push_back(d);
      lat_q.push_back(lat);
      rd_q.push_back(rd);
      if (lat >= 1 && lat <= TMO) exp_q.push_back({1'b0, rd});
      else                        exp_q.push_back({1'b1, {DOUT{1'b0}}});
    end
  endtask

  // Master model: end_send arrives lat cycles after the send_data cycle (lat 0 = never).
  int m_cnt = 0;
  logic [DOUT-1:0] m_val = '0;
  always @(negedge CLK) begin
    end_send  = 1'b0;
    data_read = DOUT'($urandom);
    if (reset) begin
      m_cnt = 0;
    end else begin
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          end_send  = 1'b1;
          data_read = m_val;
          es_idx    = cyc;
        end
      end
      if (send_data && lat_q.size() != 0) begin
        m_cnt = lat_q.pop_front();
        m_val = rd_q.pop_front();
      end
    end
  end

  // Monitor / scoreboard.
  logic         prev_v = 1'b0, prev_r = 1'b0, prev_sd = 1'b0;
  logic [W-1:0] prev_rsp = '0;
  logic [W-1:0] e;
  always @(negedge CLK) begin
    if (!reset) begin
      if (config_enable) begin
        ce_cnt++;
        last_ce = cyc;
        check("cfg_pulse_expected", 64'(cfg_exp_q.size() != 0), 1);
        if (cfg_exp_q.size() != 0) check("data_config", data_config, cfg_exp_q.pop_front());
      end
      if (send_data) begin
        sd_cnt++;
        last_sd = cyc;
        check("send_data_single", prev_sd, 0);
        check("send_pulse_expected", 64'(sd_exp_q.size() != 0), 1);
        if (sd_exp_q.size() != 0) check("data_send", data_send, sd_exp_q.pop_front());
      end
      if (rsp_valid && !prev_v) first_rsp = cyc;
      if (prev_v && !prev_r) begin
        check("rsp_held_valid", rsp_valid, 1);
        check("rsp_held_payload", {rsp_err, rsp_data}, prev_rsp);
      end
      if (rsp_valid && rsp_ready) begin
        check("rsp_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp_data", rsp_data, e[DOUT-1:0]);
          check("rsp_err", rsp_err, e[DOUT]);
        end
      end
    end
    prev_v   = rsp_valid && !reset;
    prev_r   = rsp_ready;
    prev_sd  = send_data && !reset;
    prev_rsp = {rsp_err, rsp_data};
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_cmd(input logic [15:0] cfg, input logic [DIN-1:0] d, input int lat,
                          input logic [DOUT-1:0] rd, output int n_idx);
    int w;
    w = 0;
    cmd_valid  = 1'b1;
    cmd_config = cfg;
    cmd_data   = d;
    @(negedge CLK);
    while (!cmd_ready && w < 300) begin
      @(negedge CLK);
      w++;
    end
    check("push_accepted", cmd_ready, 1);
    n_idx = cyc + 1;
    if (cmd_ready) model_accept(cfg, d, lat, rd);
    @(posedge CLK);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound, input bit rand_rdy);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || busy) && w < bound) begin
      rsp_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      w++;
    end
    rsp_ready = 1'b1;
    check("drain_done", exp_q.size(), 0);
  endtask

  function automatic logic [15:0] rand_launch_cfg();
    return {8'($urandom_range(1, 64)), 1'b0, 6'($urandom), 1'b1};
  endfunction

  function automatic int rand_lat();
    int p;
    p = $urandom_range(0, 9);
    if (p == 0) return 0;
    if (p == 1) return TMO;
    if (p == 2) return TMO + 1;
    return $urandom_range(1, TMO - 1);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int n, n2, w, ce0, sd0;
    logic [15:0] cfg;

    // Reset state.
    repeat (3) tick();
    @(negedge CLK);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_outputs", {rsp_err, rsp_data, config_enable, send_data, busy}, 0);
    check("rst_data_config", data_config, 0);
    check("rst_data_send", data_send, 0);
    check("rst_state", state_dbg, 0);
    tick();
    reset = 1'b0;
    rsp_ready = 1'b1;
    tick();

    // Single command, master replies 40 cycles after send_data.
    push_cmd(16'h1F01, 64'hA5A5_0000_0000_0000, 40, 32'hDEAD_BEEF, n);
    wait_drain(200, 1'b0);
    check("t1_cfg_en_time", 64'(last_ce - n), 1);
    check("t1_send_time", 64'(last_sd - n), 3);
    check("t1_rsp_after_end", 64'(first_rsp - es_idx), 1);

    // Fill: one command parked in RESP, then four more fill the FIFO.
    rsp_ready = 1'b0;
    push_cmd(rand_launch_cfg(), {$urandom, $urandom}, $urandom_range(1, TMO - 1), DOUT'($urandom), n);
    w = 0;
    while (!rsp_valid && w < 200) begin tick(); w++; end
    check("fill_first_rsp_valid", rsp_valid, 1);
    for (int i = 0; i < 4; i++) begin
      push_cmd(rand_launch_cfg(), {$urandom, $urandom}, $urandom_range(1, TMO), DOUT'($urandom), n);
      if (i == 2) begin
        @(negedge CLK);
        check("fill_ready_before_full", cmd_ready, 1);
        tick();
      end
    end
    @(negedge CLK);
    check("fill_ready_low_when_full", cmd_ready, 0);
    repeat (12) tick();
    wait_drain(2000, 1'b0);

    // Config-only command.
    sd0 = sd_cnt;
    push_cmd(16'h0000, {$urandom, $urandom}, 5, DOUT'($urandom), n);
    wait_drain(100, 1'b0);
    check("cfgonly_rsp_time", 64'(first_rsp - n), 3);
    check("cfgonly_no_send", 64'(sd_cnt - sd0), 0);
    push_cmd(16'h1F81, {$urandom, $urandom}, 5, DOUT'($urandom), n);
    wait_drain(100, 1'b0);

    // Timeout, then a normal command; boundary latencies at the timeout edge.
    push_cmd(rand_launch_cfg(), {$urandom, $urandom}, 0, DOUT'($urandom), n);
    wait_drain(200, 1'b0);
    push_cmd(rand_launch_cfg(), {$urandom, $urandom}, 10, DOUT'($urandom), n);
    wait_drain(200, 1'b0);
    check("after_timeout_send_time", 64'(last_sd - n), 3);
    push_cmd(rand_launch_cfg(), {$urandom, $urandom}, TMO, DOUT'($urandom), n);
    wait_drain(200, 1'b0);
    push_cmd(rand_launch_cfg(), {$urandom, $urandom}, TMO + 1, DOUT'($urandom), n);
    wait_drain(200, 1'b0);

    // Randomized rounds with random response back-pressure.
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
        rsp_ready = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) cfg = {8'($urandom), 1'($urandom), 6'($urandom), 1'b0};
        else                            cfg = rand_launch_cfg();
        push_cmd(cfg, {$urandom, $urandom}, rand_lat(), DOUT'($urandom), n);
      end
      wait_drain(1000, 1'b1);
    end

    // Reset during WAIT with a second command queued.
    push_cmd(16'h0801, {$urandom, $urandom}, 0, DOUT'($urandom), n);
    push_cmd(16'h0901, {$urandom, $urandom}, 10, DOUT'($urandom), n2);
    w = 0;
    while (state_dbg != 3'd4 && w < 50) begin tick(); w++; end
    repeat (5) tick();
    reset = 1'b1;
    tick();
    @(negedge CLK);
    check("midrst_cmd_ready", cmd_ready, 0);
    check("midrst_outputs", {rsp_valid, rsp_err, rsp_data, config_enable, send_data, busy}, 0);
    check("midrst_data", {data_config, data_send}, 0);
    exp_q.delete(); cfg_exp_q.delete(); sd_exp_q.delete(); lat_q.delete(); rd_q.delete();
    last_cfg = '0;
    tick();
    reset = 1'b0;
    repeat (TMO + 20) tick();
    @(negedge CLK);
    check("midrst_fifo_empty_idle", busy, 0);
    check("midrst_no_rsp", rsp_valid, 0);
    tick();
    push_cmd(rand_launch_cfg(), {$urandom, $urandom}, 7, DOUT'($urandom), n);
    wait_drain(200, 1'b0);

    // Two commands with an identical config.
    push_cmd(16'h0701, {$urandom, $urandom}, 5, DOUT'($urandom), n);
    wait_drain(200, 1'b0);
    ce0 = ce_cnt;
    push_cmd(16'h0701, {$urandom, $urandom}, 5, DOUT'($urandom), n);
    wait_drain(200, 1'b0);
`ifdef SPI_SEQ_CFG_CACHE_EN
    check("cache_no_config", 64'(ce_cnt - ce0), 0);
    check("cache_send_time", 64'(last_sd - n), 1);
`else
    check("repeat_config", 64'(ce_cnt - ce0), 1);
    check("repeat_send_time", 64'(last_sd - n), 3);
`endif

    check("all_configs_seen", cfg_exp_q.size(), 0);
    check("all_sends_seen", sd_exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
